// File: rtl/mdu_pkg.sv
// Shared opcode, state and decode definitions for the HI/LO multiply-divide unit.
// Macro MDU_MADD_EN enables the madd opcode.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MADD  = 3'd7
  } mdu_op_e;

  // Reserved for a 4-bit opcode, where op[3] selects the unsigned madd variant.
  localparam logic [3:0] MDU_MADDU = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  function automatic logic mdu_is_long(input logic [2:0] op);
    logic r;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic mdu_is_move(input logic [2:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for every MDU opcode; divide by zero holds hi/lo.
// Macro MDU_MADD_EN adds the multiply-accumulate path.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] sprod_s;
  logic [63:0]        uprod_s;
  logic               div_zero_s;
  logic               div_ovf_s;
  logic [31:0]        divisor_s;
  logic signed [31:0] squot_s;
  logic signed [31:0] srem_s;
  logic [31:0]        uquot_s;
  logic [31:0]        urem_s;

  assign sprod_s    = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign uprod_s    = {32'd0, rs} * {32'd0, rt};
  assign div_zero_s = (rt == 32'd0);
  assign div_ovf_s  = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
  // Dividing by 1 instead keeps the dividers X-free and yields the wrapped quotient for -2^31/-1.
  assign divisor_s  = (div_zero_s || div_ovf_s) ? 32'd1 : rt;
  assign squot_s    = $signed(rs) / $signed(divisor_s);
  assign srem_s     = $signed(rs) % $signed(divisor_s);
  assign uquot_s    = rs / divisor_s;
  assign urem_s     = rs % divisor_s;

  // Result select per opcode.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = sprod_s;
      MDU_MULTU: {res_hi, res_lo} = uprod_s;
      MDU_DIV: begin
        if (div_zero_s) begin
          res_hi = hi;
          res_lo = lo;
        end else begin
          res_hi = srem_s;
          res_lo = squot_s;
        end
      end
      MDU_DIVU: begin
        if (div_zero_s) begin
          res_hi = hi;
          res_lo = lo;
        end else begin
          res_hi = urem_s;
          res_lo = uquot_s;
        end
      end
      MDU_MTHI: res_hi = rs;
      MDU_MTLO: res_lo = rs;
`ifdef MDU_MADD_EN
      MDU_MADD: {res_hi, res_lo} = {hi, lo} + sprod_s;
`endif
      default: begin
        res_hi = hi;
        res_lo = lo;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide sequencer: fixed-latency busy counter, pending result, D-stage stall.
// Macro MDU_MADD_EN enables madd (accepted as a MULT_CYCLES operation).
module muldiv_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        mdu_use_D,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  mdu_state_e  state_r, state_nxt_s;
  logic [3:0]  cnt_r;
  logic [31:0] p_hi_r, p_lo_r;
  logic [31:0] hi_r, lo_r;
  logic [31:0] res_hi_s, res_lo_s;
  logic        launch_s, move_s;
  logic [3:0]  n_cycles_s;
  logic        busy_s;

  mdu_arith u_arith (
    .op     (op_E),
    .rs     (rs_E),
    .rt     (rt_E),
    .hi     (hi_r),
    .lo     (lo_r),
    .res_hi (res_hi_s),
    .res_lo (res_lo_s)
  );

  assign launch_s   = start_E && mdu_is_long(op_E);
  assign move_s     = start_E && mdu_is_move(op_E);
  assign n_cycles_s = ((op_E == MDU_DIV) || (op_E == MDU_DIVU)) ? DIV_N : MULT_N;
  assign hi         = hi_r;
  assign lo         = lo_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a start while BUSY is ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == 4'd1) state_nxt_s = IDLE;
        else               state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Counter, pending result and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r  <= 4'd0;
      p_hi_r <= 32'd0;
      p_lo_r <= 32'd0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            p_hi_r <= res_hi_s;
            p_lo_r <= res_lo_s;
            cnt_r  <= n_cycles_s;
          end else if (move_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
          end
        end
        BUSY: begin
          if (cnt_r == 4'd1) begin
            hi_r  <= p_hi_r;
            lo_r  <= p_lo_r;
            cnt_r <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: cnt_r <= 4'd0;
      endcase
    end
  end

  // Outputs: busy decodes the state register, stall covers the launch cycle too.
  always_comb begin
    busy_s  = (state_r == BUSY);
    busy    = busy_s;
    stall_D = mdu_use_D & (busy_s | start_E);
  end

endmodule
